arbitro_puerto_memoria: RTL and testbench

- Shares one synchronous memory port between two requesters:
  - A: pipeline data-memory stage.
  - B: debug/UART unit.
- Drives the `Sel` of the existing 2:1 data/address/write-data muxes in front of the memory, plus the memory enable.
- Sequences each access through a fixed memory latency and returns a one-cycle acknowledge to the winner.
- Sits between the requesters and the memory, next to the `Mux_2in_1out` instances it controls.

---
 rtl/arbitro_puerto_memoria_pkg.sv | 44 ++++
 rtl/arbitro_puerto_memoria_if.sv | 28 ++
 rtl/arbitro_puerto_memoria_contador_latencia.sv | 29 ++
 rtl/arbitro_puerto_memoria.sv | 108 ++++++++++
 tb/tb_arbitro_puerto_memoria.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_puerto_memoria_pkg.sv
// Shared definitions for the memory-port arbiter: state encodings,
// requester ids, arbitration modes and the grant-selection function.
package arbitro_puerto_memoria_pkg;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } estado_t;

  // Requester ids; the value doubles as the datapath mux select.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Arbitration modes.
  localparam int MODO_RR   = 0;  // round-robin
  localparam int MODO_FIJO = 1;  // fixed priority, A wins

  // Chooses the winner among the pending requests.
  // With both pending: fixed mode gives A, round-robin gives whoever
  // was not granted last.
  function automatic req_id_t elegir(input logic    req_a,
                                     input logic    req_b,
                                     input req_id_t ultimo,
                                     input logic    modo_fijo);
    req_id_t gana;
    // NOTE: the result gets a default before any branch, so every path
    // through the function assigns it and combinational users infer no latch.
    gana = REQ_A;
    if (req_a && req_b) begin
      if (modo_fijo)             gana = REQ_A;
      else if (ultimo == REQ_A)  gana = REQ_B;
      else                       gana = REQ_A;
    end else if (req_b) begin
      gana = REQ_B;
    end
    return gana;
  endfunction

endpackage

// File: rtl/arbitro_puerto_memoria_if.sv
// Handshake and memory-control signals between the two requesters,
// the arbiter and the datapath muxes in front of the memory.
interface arbitro_puerto_memoria_if;

  logic Req_A;   // request from the pipeline data-memory stage
  logic We_A;    // write qualifier for A
  logic Req_B;   // request from the debug/UART unit
  logic We_B;    // write qualifier for B
  logic Sel;     // datapath mux select (0 = A, 1 = B)
  logic Mem_En;  // one-cycle memory access strobe
  logic Mem_We;  // write enable, meaningful only with Mem_En
  logic Ack_A;   // completion pulse to A
  logic Ack_B;   // completion pulse to B
  logic Busy;    // transaction in flight

  // Requester side: drives requests, observes grant and completion.
  modport master (
    output Req_A, We_A, Req_B, We_B,
    input  Sel, Mem_En, Mem_We, Ack_A, Ack_B, Busy
  );

  // Arbiter side.
  modport slave (
    input  Req_A, We_A, Req_B, We_B,
    output Sel, Mem_En, Mem_We, Ack_A, Ack_B, Busy
  );

endinterface

// File: rtl/arbitro_puerto_memoria_contador_latencia.sv
// 4-bit loadable down-counter with enable and zero flag; times the
// memory latency between the access strobe and the acknowledge.
module contador_latencia (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carga,  // load valor this cycle
  input  logic       en,     // decrement this cycle
  input  logic [3:0] valor,
  output logic       cero    // count is zero
);

  logic [3:0] cuenta;

  // Load takes precedence over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated only with non-blocking (<=)
    // assignments so every register samples pre-edge values.
    if (!rst_n) begin
      cuenta <= 4'd0;
    end else if (carga) begin
      cuenta <= valor;
    end else if (en && (cuenta != 4'd0)) begin
      cuenta <= cuenta - 4'd1;
    end
  end

  assign cero = (cuenta == 4'd0);

endmodule

// File: rtl/arbitro_puerto_memoria.sv
// Arbiter sharing one synchronous memory port between the pipeline
// data-memory stage (A) and the debug/UART unit (B). Drives the Sel of
// the datapath muxes and the memory strobe, sequences the fixed memory
// latency and returns a one-cycle acknowledge to the winner.
module arbitro_puerto_memoria
  import arbitro_puerto_memoria_pkg::*;
#(
  parameter int LAT  = 2,  // read latency Mem_En -> data valid, 1..15
  parameter int MODO = 0   // MODO_RR or MODO_FIJO
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  arbitro_puerto_memoria_if.slave   bus
);

  // Counter start value: the WAIT phase lasts LAT-1 cycles, and the
  // counter is examined once per WAIT cycle down to zero.
  localparam logic [3:0] CARGA_LAT = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;
  localparam logic       ES_FIJO   = (MODO == MODO_FIJO);

  estado_t estado;
  req_id_t ganador;   // winner of the transaction in flight
  req_id_t ultimo;    // last requester acknowledged
  req_id_t elegido;   // combinational choice among pending requests
  logic    cero;

  logic sel_q, mem_en_q, mem_we_q, ack_a_q, ack_b_q, busy_q;

  assign elegido = elegir(bus.Req_A, bus.Req_B, ultimo, ES_FIJO);

  contador_latencia u_contador (
    .clk   (Clk),
    .rst_n (Reset_n),
    .carga (estado == ISSUE),
    .en    (estado == WAIT),
    .valor (CARGA_LAT),
    .cero  (cero)
  );

  // FSM with outputs registered together with the state, so they are
  // glitch-free and only one requester is ever strobed or acknowledged.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: every register, the registered outputs included, has a
      // reset value so all outputs drop to 0 the moment Reset_n falls.
      estado   <= IDLE;
      ganador  <= REQ_A;
      ultimo   <= REQ_B;
      sel_q    <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (bus.Req_A || bus.Req_B) begin
            ganador  <= elegido;
            sel_q    <= (elegido == REQ_B);
            mem_en_q <= 1'b1;
            mem_we_q <= (elegido == REQ_B) ? bus.We_B : bus.We_A;
            busy_q   <= 1'b1;
            estado   <= ISSUE;
          end
        end

        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (LAT == 1) begin
            ack_a_q <= (ganador == REQ_A);
            ack_b_q <= (ganador == REQ_B);
            estado  <= ACK;
          end else begin
            estado  <= WAIT;
          end
        end

        WAIT: begin
          if (cero) begin
            ack_a_q <= (ganador == REQ_A);
            ack_b_q <= (ganador == REQ_B);
            estado  <= ACK;
          end
        end

        ACK: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy_q  <= 1'b0;
          ultimo  <= ganador;
          estado  <= IDLE;
        end

        default: estado <= IDLE;
      endcase
    end
  end

  assign bus.Sel    = sel_q;
  assign bus.Mem_En = mem_en_q;
  assign bus.Mem_We = mem_we_q;
  assign bus.Ack_A  = ack_a_q;
  assign bus.Ack_B  = ack_b_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_arbitro_puerto_memoria.sv
// Bench for arbitro_puerto_memoria. Four instances cover the parameter
// points (LAT=2 round-robin, LAT=2 fixed, LAT=1, LAT=4). Stimulus pushes
// expected memory strobes and acknowledges into queues; a monitor pops
// and compares them whenever any instance raises Mem_En or an Ack.
module tb_arbitro_puerto_memoria;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arbitro_puerto_memoria_if if0 ();
  arbitro_puerto_memoria_if if1 ();
  arbitro_puerto_memoria_if if2 ();
  arbitro_puerto_memoria_if if3 ();

  arbitro_puerto_memoria #(.LAT(2), .MODO(0)) dut0 (.Clk(clk), .Reset_n(reset_n), .bus(if0));
  arbitro_puerto_memoria #(.LAT(2), .MODO(1)) dut1 (.Clk(clk), .Reset_n(reset_n), .bus(if1));
  arbitro_puerto_memoria #(.LAT(1), .MODO(0)) dut2 (.Clk(clk), .Reset_n(reset_n), .bus(if2));
  arbitro_puerto_memoria #(.LAT(4), .MODO(0)) dut3 (.Clk(clk), .Reset_n(reset_n), .bus(if3));

  // Expected event: instance, cycle, requester id (sel) and write flag.
  typedef struct {
    int   inst;
    int   cyc;
    logic sel;
    logic we;
  } ev_t;

  ev_t en_q[$];
  ev_t ack_q[$];
  ev_t e;

  logic [3:0] v_en, v_we, v_sel, v_acka, v_ackb;
  assign v_en   = {if3.Mem_En, if2.Mem_En, if1.Mem_En, if0.Mem_En};
  assign v_we   = {if3.Mem_We, if2.Mem_We, if1.Mem_We, if0.Mem_We};
  assign v_sel  = {if3.Sel,    if2.Sel,    if1.Sel,    if0.Sel};
  assign v_acka = {if3.Ack_A,  if2.Ack_A,  if1.Ack_A,  if0.Ack_A};
  assign v_ackb = {if3.Ack_B,  if2.Ack_B,  if1.Ack_B,  if0.Ack_B};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_en(input int inst, input int c, input logic sel, input logic we);
    ev_t x;
    x.inst = inst; x.cyc = c; x.sel = sel; x.we = we;
    en_q.push_back(x);
  endtask

  task automatic push_ack(input int inst, input int c, input logic id);
    ev_t x;
    x.inst = inst; x.cyc = c; x.sel = id; x.we = 1'b0;
    ack_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Monitor: compare every strobe/acknowledge against the queues.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (v_en[i]) begin
        if (en_q.size() == 0) begin
          check($sformatf("mem_en unexpected inst%0d", i), 32'd1, 32'd0);
        end else begin
          e = en_q.pop_front();
          check("mem_en inst", 32'(i), 32'(e.inst));
          check("mem_en cycle", 32'(cyc), 32'(e.cyc));
          check("mem_en sel", 32'(v_sel[i]), 32'(e.sel));
          check("mem_en we", 32'(v_we[i]), 32'(e.we));
        end
      end
      if (v_acka[i] || v_ackb[i]) begin
        check($sformatf("ack both inst%0d", i), 32'(v_acka[i] & v_ackb[i]), 32'd0);
        if (ack_q.size() == 0) begin
          check($sformatf("ack unexpected inst%0d", i), 32'd1, 32'd0);
        end else begin
          e = ack_q.pop_front();
          check("ack inst", 32'(i), 32'(e.inst));
          check("ack cycle", 32'(cyc), 32'(e.cyc));
          check("ack id", 32'(v_ackb[i]), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int c1;
    {if0.Req_A, if0.We_A, if0.Req_B, if0.We_B} = 4'b0;
    {if1.Req_A, if1.We_A, if1.Req_B, if1.We_B} = 4'b0;
    {if2.Req_A, if2.We_A, if2.Req_B, if2.We_B} = 4'b0;
    {if3.Req_A, if3.We_A, if3.Req_B, if3.We_B} = 4'b0;

    // Reset state of all outputs.
    tick(2);
    check("reset outs inst0", 32'({if0.Sel, if0.Mem_En, if0.Mem_We, if0.Ack_A, if0.Ack_B, if0.Busy}), 32'd0);
    check("reset outs inst3", 32'({if3.Sel, if3.Mem_En, if3.Mem_We, if3.Ack_A, if3.Ack_B, if3.Busy}), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Single read from A, LAT=2.
    c0 = cyc;
    if0.Req_A = 1'b1; if0.We_A = 1'b0;
    push_en(0, c0 + 1, 1'b0, 1'b0);
    push_ack(0, c0 + 3, 1'b0);
    tick(1);
    check("t1 c1 sel", 32'(if0.Sel), 32'd0);
    check("t1 c1 mem_en", 32'(if0.Mem_En), 32'd1);
    check("t1 c1 busy", 32'(if0.Busy), 32'd1);
    tick(1);
    check("t1 c2 mem_en", 32'(if0.Mem_En), 32'd0);
    check("t1 c2 busy", 32'(if0.Busy), 32'd1);
    check("t1 c2 ack_a", 32'(if0.Ack_A), 32'd0);
    tick(1);
    check("t1 c3 ack_a", 32'(if0.Ack_A), 32'd1);
    check("t1 c3 busy", 32'(if0.Busy), 32'd1);
    if0.Req_A = 1'b0;
    tick(1);
    check("t1 c4 busy", 32'(if0.Busy), 32'd0);
    check("t1 c4 ack_a", 32'(if0.Ack_A), 32'd0);
    tick(2);

    // Round-robin with both requests held: A, B, A, B every 4 cycles.
    do_reset();
    c0 = cyc;
    if0.We_A = 1'b0; if0.We_B = 1'b1;
    if0.Req_A = 1'b1; if0.Req_B = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_en(0, c0 + 1 + 4 * k, k[0], k[0]);
      push_ack(0, c0 + 3 + 4 * k, k[0]);
    end
    tick(15);
    if0.Req_A = 1'b0; if0.Req_B = 1'b0;
    tick(1);
    check("t2 idle busy", 32'(if0.Busy), 32'd0);
    tick(2);

    // Fixed priority with both requests held: A four times, B never.
    do_reset();
    c0 = cyc;
    if1.We_A = 1'b1; if1.We_B = 1'b0;
    if1.Req_A = 1'b1; if1.Req_B = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_en(1, c0 + 1 + 4 * k, 1'b0, 1'b1);
      push_ack(1, c0 + 3 + 4 * k, 1'b0);
    end
    tick(15);
    check("t3 last sel", 32'(if1.Sel), 32'd0);
    if1.Req_A = 1'b0; if1.Req_B = 1'b0;
    tick(1);
    check("t3 idle busy", 32'(if1.Busy), 32'd0);
    tick(2);

    // Write from B with LAT=1.
    do_reset();
    c0 = cyc;
    if2.Req_B = 1'b1; if2.We_B = 1'b1;
    push_en(2, c0 + 1, 1'b1, 1'b1);
    push_ack(2, c0 + 2, 1'b1);
    tick(1);
    check("t4 c1 sel", 32'(if2.Sel), 32'd1);
    check("t4 c1 mem_en", 32'(if2.Mem_En), 32'd1);
    check("t4 c1 mem_we", 32'(if2.Mem_We), 32'd1);
    tick(1);
    check("t4 c2 ack_b", 32'(if2.Ack_B), 32'd1);
    check("t4 c2 mem_en", 32'(if2.Mem_En), 32'd0);
    if2.Req_B = 1'b0; if2.We_B = 1'b0;
    tick(1);
    check("t4 c3 busy", 32'(if2.Busy), 32'd0);
    check("t4 c3 sel held", 32'(if2.Sel), 32'd1);
    tick(2);

    // Asynchronous reset during WAIT with LAT=4, then a fresh access.
    do_reset();
    c0 = cyc;
    if3.Req_A = 1'b1; if3.We_A = 1'b1;
    push_en(3, c0 + 1, 1'b0, 1'b1);
    tick(3);
    check("t5 wait busy", 32'(if3.Busy), 32'd1);
    reset_n = 1'b0;
    if3.Req_A = 1'b0;
    #1;
    check("t5 async outs", 32'({if3.Sel, if3.Mem_En, if3.Mem_We, if3.Ack_A, if3.Ack_B, if3.Busy}), 32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(1);
    c1 = cyc;
    if3.Req_A = 1'b1;
    push_en(3, c1 + 1, 1'b0, 1'b1);
    push_ack(3, c1 + 5, 1'b0);
    tick(4);
    check("t5 c4 ack_a", 32'(if3.Ack_A), 32'd0);
    tick(1);
    check("t5 c5 ack_a", 32'(if3.Ack_A), 32'd1);
    if3.Req_A = 1'b0; if3.We_A = 1'b0;
    tick(2);

    // A drops its request during WAIT (fixed priority): A still
    // acknowledged once, then B is granted.
    do_reset();
    c0 = cyc;
    if1.We_A = 1'b0; if1.We_B = 1'b0;
    if1.Req_A = 1'b1; if1.Req_B = 1'b1;
    push_en(1, c0 + 1, 1'b0, 1'b0);
    push_ack(1, c0 + 3, 1'b0);
    push_en(1, c0 + 5, 1'b1, 1'b0);
    push_ack(1, c0 + 7, 1'b1);
    tick(2);
    if1.Req_A = 1'b0;
    tick(5);
    if1.Req_B = 1'b0;
    tick(3);
    check("t6 idle busy", 32'(if1.Busy), 32'd0);

    check("en queue drained", 32'(en_q.size()), 32'd0);
    check("ack queue drained", 32'(ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
